// File: rtl/mcpu_ctrl.sv
// Multi-cycle control FSM for the RIJ datapath: decodes IR OP/funct and drives the
// PC/IR/register/RAM enables and the datapath mux selects, one state per step clock.
module mcpu_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      OP,
    input  logic [5:0]      funct,
    input  logic            ZF,
    output logic            PC_Write,
    output logic [1:0]      PC_s,
    output logic            IR_Write,
    output logic            Reg_Write,
    output logic            Mem_Write,
    output logic [2:0]      ALU_OP,
    output logic            ALU_A_s,
    output logic            ALU_B_s,
    output logic            imm_s,
    output logic [1:0]      w_r_s,
    output logic [1:0]      wr_data_s,
    output logic [ST_W-1:0] state,
    output logic            illegal
);

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 4'd0,
        S_IF    = 4'd1,
        S_ID    = 4'd2,
        S_EX_R  = 4'd3,
        S_EX_I  = 4'd4,
        S_MA    = 4'd5,
        S_MRD   = 4'd6,
        S_MWR   = 4'd7,
        S_WB_LW = 4'd8,
        S_WB    = 4'd9,
        S_BR    = 4'd10,
        S_ERR   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_XOR = 3'b010;
    localparam logic [2:0] A_NOR = 3'b011;
    localparam logic [2:0] A_ADD = 3'b100;
    localparam logic [2:0] A_SUB = 3'b101;
    localparam logic [2:0] A_SLT = 3'b110;
    localparam logic [2:0] A_SLL = 3'b111;

    state_t cur, nxt;

    logic       r_ok, is_sll, imm_i;
    logic [2:0] alu_r, alu_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_IDLE;
        else      cur <= nxt;
    end

    // R-type and I-type ALU decode; held from EX through WB so ALU_F stays valid.
    always_comb begin
        r_ok  = 1'b1;
        alu_r = A_ADD;
        case (funct)
            6'b100000: alu_r = A_ADD;
            6'b100010: alu_r = A_SUB;
            6'b100100: alu_r = A_AND;
            6'b100101: alu_r = A_OR;
            6'b100110: alu_r = A_XOR;
            6'b100111: alu_r = A_NOR;
            6'b101010: alu_r = A_SLT;
            6'b000000: alu_r = A_SLL;
            default:   r_ok  = 1'b0;
        endcase
        is_sll = (funct == 6'b000000);
        alu_i  = A_ADD;
        imm_i  = 1'b0;
        case (OP)
            OP_ADDI: begin alu_i = A_ADD; imm_i = 1'b1; end
            OP_SLTI: begin alu_i = A_SLT; imm_i = 1'b1; end
            OP_ANDI: alu_i = A_AND;
            OP_ORI:  alu_i = A_OR;
            OP_XORI: alu_i = A_XOR;
            default: ;
        endcase
    end

    always_comb begin
        nxt       = cur;
        PC_Write  = 1'b0;
        PC_s      = 2'b00;
        IR_Write  = 1'b0;
        Reg_Write = 1'b0;
        Mem_Write = 1'b0;
        ALU_OP    = 3'b000;
        ALU_A_s   = 1'b0;
        ALU_B_s   = 1'b0;
        imm_s     = 1'b0;
        w_r_s     = 2'b00;
        wr_data_s = 2'b00;
        illegal   = 1'b0;
        case (cur)
            S_IDLE: nxt = S_IF;
            S_IF: begin
                IR_Write = 1'b1;
                PC_Write = 1'b1;
                nxt      = S_ID;
            end
            S_ID: begin
                case (OP)
                    OP_R: begin
                        if (funct == FN_JR) begin
                            PC_Write = 1'b1;
                            PC_s     = 2'b01;
                            nxt      = S_IF;
                        end else if (r_ok) nxt = S_EX_R;
                        else               nxt = S_ERR;
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EX_I;
                    OP_LW, OP_SW:   nxt = S_MA;
                    OP_BEQ, OP_BNE: nxt = S_BR;
                    OP_J: begin
                        PC_Write = 1'b1;
                        PC_s     = 2'b11;
                        nxt      = S_IF;
                    end
                    OP_JAL: begin
                        // $31 and PC load on the same edge, so the link is the old PC+4
                        PC_Write  = 1'b1;
                        PC_s      = 2'b11;
                        Reg_Write = 1'b1;
                        w_r_s     = 2'b10;
                        wr_data_s = 2'b10;
                        nxt       = S_IF;
                    end
                    default: nxt = S_ERR;
                endcase
            end
            S_EX_R: begin
                ALU_OP  = alu_r;
                ALU_A_s = is_sll;
                nxt     = S_WB;
            end
            S_EX_I: begin
                ALU_OP  = alu_i;
                ALU_B_s = 1'b1;
                imm_s   = imm_i;
                nxt     = S_WB;
            end
            S_WB: begin
                Reg_Write = 1'b1;
                if (OP == OP_R) begin
                    ALU_OP  = alu_r;
                    ALU_A_s = is_sll;
                end else begin
                    ALU_OP  = alu_i;
                    ALU_B_s = 1'b1;
                    imm_s   = imm_i;
                    w_r_s   = 2'b01;
                end
                nxt = S_IF;
            end
            S_MA, S_MRD, S_MWR, S_WB_LW: begin
                // address computation stays live for the whole memory access
                ALU_OP  = A_ADD;
                ALU_B_s = 1'b1;
                imm_s   = 1'b1;
                case (cur)
                    S_MA:    nxt = (OP == OP_LW) ? S_MRD : S_MWR;
                    S_MRD:   nxt = S_WB_LW;
                    S_MWR: begin
                        Mem_Write = 1'b1;
                        nxt       = S_IF;
                    end
                    default: begin
                        Reg_Write = 1'b1;
                        w_r_s     = 2'b01;
                        wr_data_s = 2'b01;
                        nxt       = S_IF;
                    end
                endcase
            end
            S_BR: begin
                ALU_OP   = A_SUB;
                PC_s     = 2'b10;
                PC_Write = ((OP == OP_BEQ) & ZF) | ((OP == OP_BNE) & ~ZF);
                nxt      = S_IF;
            end
            S_ERR: begin
                illegal = 1'b1;
                nxt     = S_ERR;
            end
            default: nxt = S_ERR;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: each driven cycle queues the expected state/output
// word, and a negedge monitor pops and compares it against the live outputs.
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] OP = '0, funct = '0;
    logic       ZF = 1'b0;
    logic       PC_Write, IR_Write, Reg_Write, Mem_Write, ALU_A_s, ALU_B_s, imm_s, illegal;
    logic [1:0] PC_s, w_r_s, wr_data_s;
    logic [2:0] ALU_OP;
    logic [3:0] state;

    always #5 clk = ~clk;

    mcpu_ctrl #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .OP(OP), .funct(funct), .ZF(ZF),
        .PC_Write(PC_Write), .PC_s(PC_s), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
        .Mem_Write(Mem_Write), .ALU_OP(ALU_OP), .ALU_A_s(ALU_A_s), .ALU_B_s(ALU_B_s),
        .imm_s(imm_s), .w_r_s(w_r_s), .wr_data_s(wr_data_s), .state(state), .illegal(illegal)
    );

    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    wire [20:0] obs = {state, PC_Write, PC_s, IR_Write, Reg_Write, Mem_Write, ALU_OP,
                       ALU_A_s, ALU_B_s, imm_s, w_r_s, wr_data_s, illegal};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // {state, PC_Write, PC_s, IR_Write, Reg_Write, Mem_Write, ALU_OP, A_s, B_s, imm_s, w_r_s, wr_data_s, illegal}
    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic rw, input logic mw,
                                       input logic [2:0] aop, input logic as_, input logic bs,
                                       input logic ims, input logic [1:0] wrs, input logic [1:0] wds,
                                       input logic ill);
        return {st, pcw, pcs, irw, rw, mw, aop, as_, bs, ims, wrs, wds, ill};
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.tag, {11'd0, obs}, {11'd0, e.v});
            check("excl_wr", 32'(int'(Reg_Write) + int'(Mem_Write) + int'(IR_Write) <= 1), 32'd1);
        end
    end

    task automatic step(input string tag, input logic [20:0] v);
        sb_q.push_back('{v, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic zf);
        OP = op; funct = fn; ZF = zf;
        step("if", mk(4'd1, 1, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));
        step("id", mk(4'd2, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [2:0] aop, input logic as_);
        fetch(6'b000000, fn, 1'b0);
        step({tag, "_ex"}, mk(4'd3, 0, 2'b00, 0, 0, 0, aop, as_, 0, 0, 2'b00, 2'b00, 0));
        step({tag, "_wb"}, mk(4'd9, 0, 2'b00, 0, 1, 0, aop, as_, 0, 0, 2'b00, 2'b00, 0));
    endtask

    task automatic itype(input string tag, input logic [5:0] op, input logic [2:0] aop, input logic ims);
        fetch(op, 6'h00, 1'b0);
        step({tag, "_ex"}, mk(4'd4, 0, 2'b00, 0, 0, 0, aop, 0, 1, ims, 2'b00, 2'b00, 0));
        step({tag, "_wb"}, mk(4'd9, 0, 2'b00, 0, 1, 0, aop, 0, 1, ims, 2'b01, 2'b00, 0));
    endtask

    task automatic branch(input string tag, input logic [5:0] op, input logic zf, input logic taken);
        fetch(op, 6'h00, zf);
        step(tag, mk(4'd10, taken, 2'b10, 0, 0, 0, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0));
    endtask

    // One-shot ID step for the two-cycle jumps; fetch's ID entry is replaced by this.
    task automatic jump(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [20:0] id_exp);
        OP = op; funct = fn; ZF = 1'b0;
        step("if", mk(4'd1, 1, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));
        step(tag, id_exp);
    endtask

    initial begin
        // reset state while rst is held low
        #2;
        check("reset_out", {11'd0, obs}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        step("idle", mk(4'd0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));

        rtype("add", 6'b100000, 3'b100, 0);
        rtype("sub", 6'b100010, 3'b101, 0);
        rtype("and", 6'b100100, 3'b000, 0);
        rtype("nor", 6'b100111, 3'b011, 0);
        rtype("slt", 6'b101010, 3'b110, 0);
        rtype("sll", 6'b000000, 3'b111, 1);

        itype("addi", 6'b001000, 3'b100, 1);
        itype("ori",  6'b001101, 3'b001, 0);
        itype("xori", 6'b001110, 3'b010, 0);
        itype("slti", 6'b001010, 3'b110, 1);

        // lw $2,4($0)
        fetch(6'b100011, 6'h04, 1'b0);
        step("lw_ma",  mk(4'd5, 0, 2'b00, 0, 0, 0, 3'b100, 0, 1, 1, 2'b00, 2'b00, 0));
        step("lw_mrd", mk(4'd6, 0, 2'b00, 0, 0, 0, 3'b100, 0, 1, 1, 2'b00, 2'b00, 0));
        step("lw_wb",  mk(4'd8, 0, 2'b00, 0, 1, 0, 3'b100, 0, 1, 1, 2'b01, 2'b01, 0));

        // sw: one Mem_Write cycle, no Reg_Write
        fetch(6'b101011, 6'h08, 1'b0);
        step("sw_ma",  mk(4'd5, 0, 2'b00, 0, 0, 0, 3'b100, 0, 1, 1, 2'b00, 2'b00, 0));
        step("sw_mwr", mk(4'd7, 0, 2'b00, 0, 0, 1, 3'b100, 0, 1, 1, 2'b00, 2'b00, 0));

        branch("beq_t",  6'b000100, 1'b1, 1'b1);
        branch("beq_nt", 6'b000100, 1'b0, 1'b0);
        branch("bne_t",  6'b000101, 1'b0, 1'b1);
        branch("bne_nt", 6'b000101, 1'b1, 1'b0);

        jump("jal_id", 6'b000011, 6'h10, mk(4'd2, 1, 2'b11, 0, 1, 0, 3'b000, 0, 0, 0, 2'b10, 2'b10, 0));
        jump("j_id",   6'b000010, 6'h10, mk(4'd2, 1, 2'b11, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));
        jump("jr_id",  6'b000000, 6'b001000, mk(4'd2, 1, 2'b01, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));

        // reset asserted in MWR clears state and enables before the next edge
        fetch(6'b101011, 6'h08, 1'b0);
        step("sw2_ma", mk(4'd5, 0, 2'b00, 0, 0, 0, 3'b100, 0, 1, 1, 2'b00, 2'b00, 0));
        check("mwr_state", 32'(state), 32'd7);
        check("mwr_memw", 32'(Mem_Write), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_en", 32'({PC_Write, IR_Write, Reg_Write, Mem_Write}), 32'd0);
        #2 rst = 1'b1;
        step("idle2", mk(4'd0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));

        // illegal opcode: ERR held for 10 clocks
        fetch(6'b111111, 6'h00, 1'b0);
        for (int i = 0; i < 10; i++)
            step("err_op", mk(4'd15, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 1));

        rst = 1'b0;
        #1;
        check("err_rst_ill", 32'(illegal), 32'd0);
        #2 rst = 1'b1;
        step("idle3", mk(4'd0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0));

        // unsupported funct under OP=0
        fetch(6'b000000, 6'b111111, 1'b0);
        step("err_fn", mk(4'd15, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 1));
        step("err_fn2", mk(4'd15, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 1));

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish by 50000");
        $fatal(1, "timeout");
    end

endmodule
